program_loader: RTL and testbench

- Writer side of the program-memory interface: the core only fetches (reads) instructions; this block loads them.
- Receives a framed byte stream over a valid/ready byte port, assembles little-endian 32-bit instruction words and writes them sequentially into program memory.
- Holds the single-cycle core in reset until a complete frame passes its checksum, then releases it.
- Sits between the serial receive front-end and the program-memory write port / core reset input at top level.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_if.sv | 21 ++
 rtl/program_loader_timeout_counter.sv | 36 +++
 rtl/program_loader.sv | 173 +++++++++++++++++
 tb/tb_program_loader.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and constants for the program loader
package program_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_SYNC   = 3'd0;
  localparam state_t ST_CNT_LO = 3'd1;
  localparam state_t ST_CNT_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_CHK    = 3'd5;
  localparam state_t ST_DONE   = 3'd6;
  localparam state_t ST_ERROR  = 3'd7;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CHECKSUM_W        = 8;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte receive port and program-memory write port
interface program_loader_if;

  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/program_loader_timeout_counter.sv
// rtl/program_loader_timeout_counter.sv - inter-byte idle timer for an in-progress frame
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count idle enabled cycles; an accepted byte or a disabled state restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // A byte arriving on the expiry edge wins, so clear masks expire.
  assign expire = enable && !clear && (cnt_q == LIMIT);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to program memory loader with core reset control
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          PROGRAM_MEMORY_DEPTH = 128,
  parameter logic [31:0] BASE_ADDR            = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE            = SYNC_BYTE_DEFAULT,
  parameter int          TIMEOUT_CYCLES       = 100000
) (
  input  logic               clk,
  input  logic               reset,
  program_loader_if.slave    bus,
  output logic               core_rst_n_o,
  output logic               done_o,
  output logic               error_o
);

  localparam int          IW      = $clog2(PROGRAM_MEMORY_DEPTH) + 1;
  localparam logic [15:0] DEPTH16 = 16'(PROGRAM_MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d, idx_next;
  logic [1:0]            nbyte_q, nbyte_d;
  logic [23:0]           word_q, word_d;
  logic [CHECKSUM_W-1:0] csum_q, csum_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic        accept, is_sync, tmo_en, tmo_expire;
  logic [15:0] n_full;

  assign bus.rx_ready_o  = (state_q != ST_WRITE);
  assign accept          = bus.rx_valid_i && bus.rx_ready_o;
  assign is_sync         = accept && (bus.rx_data_i == SYNC_BYTE);
  assign tmo_en          = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                           (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign n_full          = {bus.rx_data_i, count_q[7:0]};
  assign idx_next        = idx_q + IW'(1);

  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  // A restart SYNC byte in DONE grabs the core back in the same cycle it is taken.
  assign core_rst_n_o    = core_rst_n_q && !((state_q == ST_DONE) && is_sync);
  assign done_o          = done_q;
  assign error_o         = error_q;

  loader_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (accept),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  // Frame parser: sync, count, data assembly, one-cycle write, checksum verdict.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    nbyte_d      = nbyte_q;
    word_d       = word_q;
    csum_d       = csum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      ST_SYNC, ST_DONE, ST_ERROR: begin
        if (is_sync) begin
          state_d      = ST_CNT_LO;
          done_d       = 1'b0;
          error_d      = 1'b0;
          core_rst_n_d = 1'b0;
          csum_d       = '0;
          idx_d        = '0;
          nbyte_d      = '0;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          count_d = {8'h00, bus.rx_data_i};
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          count_d = n_full;
          nbyte_d = '0;
          if (n_full == 16'd0 || n_full > DEPTH16) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d  = csum_q + bus.rx_data_i;
          word_d  = {bus.rx_data_i, word_q[23:8]};
          nbyte_d = nbyte_q + 2'd1;
          if (nbyte_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {{(30-IW){1'b0}}, idx_q, 2'b00};
            mem_wdata_d = {bus.rx_data_i, word_q};
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        idx_d   = idx_next;
        state_d = (idx_next == count_q[IW-1:0]) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (accept) begin
          if (bus.rx_data_i == csum_q) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
    if (tmo_expire) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
    end
  end

  // State and output registers; reset drops any in-flight write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SYNC;
      count_q      <= '0;
      idx_q        <= '0;
      nbyte_q      <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      nbyte_q      <= nbyte_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  localparam int TMO = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n, done, error;

  program_loader_if bus();

  program_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus),
    .core_rst_n_o (core_rst_n),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr_o, bus.mem_wdata_o);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", bus.mem_addr_o, e.addr);
        check("wr_data", bus.mem_wdata_o, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (bus.rx_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: rx_ready_o got %b expected 1", bus.rx_ready_o);
    end
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic check_status(input string name, input logic exp_done,
                              input logic exp_err, input logic exp_core);
    @(negedge clk);
    check({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({name, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({name, "_core_rst_n"}, {31'b0, core_rst_n}, {31'b0, exp_core});
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;

    // Reset values
    #1;
    check("rst_ready", {31'b0, bus.rx_ready_o}, 32'd1);
    check("rst_we", {31'b0, bus.mem_we_o}, 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'h0000_0000);
    check("rst_wdata", bus.mem_wdata_o, 32'h0000_0000);
    check("rst_core", {31'b0, core_rst_n}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-word frame; data-byte checksum is 0xA0
    sb.push_back('{32'h0000_0000, 32'h00A0_0513});
    sb.push_back('{32'h0000_0004, 32'h0050_0593});
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'h50, 8'h00, 8'hA0});
    check_status("good", 1'b1, 1'b0, 1'b1);

    // Restart from DONE: core reset drops while the sync byte is being taken
    @(negedge clk);
    bus.rx_data_i  = 8'hA5;
    bus.rx_valid_i = 1'b1;
    #1;
    check("restart_core_comb", {31'b0, core_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    check("restart_done_clr", {31'b0, done}, 32'd0);
    check("restart_core_held", {31'b0, core_rst_n}, 32'd0);

    // Zero word count
    send_frame('{8'h00, 8'h00});
    check_status("count0", 1'b0, 1'b1, 1'b0);

    // Word count one above depth
    send_frame('{8'hA5, 8'h81, 8'h00});
    check_status("count129", 1'b0, 1'b1, 1'b0);

    // Bad checksum: both words still written
    sb.push_back('{32'h0000_0000, 32'h00A0_0513});
    sb.push_back('{32'h0000_0004, 32'h0050_0593});
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'h50, 8'h00, 8'h9D});
    check_status("badsum", 1'b0, 1'b1, 1'b0);

    // Timeout after the second data byte, then recovery
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05});
    repeat (TMO + 4) @(posedge clk);
    check_status("timeout", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    @(negedge clk);
    check("timeout_err_clr", {31'b0, error}, 32'd0);
    sb.push_back('{32'h0000_0000, 32'h00A0_0513});
    send_frame('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8});
    check_status("recover", 1'b1, 1'b0, 1'b1);

    // Leading garbage, plus an idle gap just under the timeout
    sb.push_back('{32'h0000_0000, 32'h0050_0593});
    send_frame('{8'h00, 8'hFF, 8'h11, 8'hA5, 8'h01, 8'h00, 8'h93, 8'h05});
    repeat (TMO - 3) @(posedge clk);
    send_frame('{8'h50, 8'h00, 8'hE8});
    check_status("garbage", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-DATA
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, bus.rx_ready_o}, 32'd1);
    check("midrst_we", {31'b0, bus.mem_we_o}, 32'd0);
    check("midrst_addr", bus.mem_addr_o, 32'h0000_0000);
    check("midrst_wdata", bus.mem_wdata_o, 32'h0000_0000);
    check("midrst_core", {31'b0, core_rst_n}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_error", {31'b0, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{32'h0000_0000, 32'h00A0_0513});
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8});
    check_status("after_rst", 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
